// File: rtl/bcd_pkg.sv
// Shared decimal/BCD definitions for the converter, the display decoder and bin_to_bcd.
package bcd_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      FIN  = 2'd2
   } bcd_state_e;

   localparam logic [3:0] BCD_MAX  = 4'd9;
   localparam int         DEC_BASE = 10;

endpackage

// File: rtl/bcd_mac_step.sv
// One decimal accumulate step: acc*10 + digit, saturated to OUT_W bits.
module bcd_mac_step
   import bcd_pkg::*;
#(
   parameter int OUT_W = 8
) (
   input  logic [OUT_W-1:0] acc,
   input  logic [3:0]       digit,
   output logic [OUT_W-1:0] acc_next,
   output logic             ovf
);

   // OUT_W+4 bits hold the worst case (2^OUT_W-1)*10+9 without wrapping.
   logic [OUT_W+3:0] wide;
   logic [OUT_W+3:0] limit;

   // Multiply-add in the widened domain, then clamp to the output range.
   always_comb begin
      wide     = ({4'd0, acc} * (OUT_W+4)'(DEC_BASE)) + {{OUT_W{1'b0}}, digit};
      limit    = {4'd0, {OUT_W{1'b1}}};
      ovf      = (wide > limit);
      acc_next = ovf ? {OUT_W{1'b1}} : wide[OUT_W-1:0];
   end

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD to binary converter, one digit per clock, start/busy/done handshake.
//
// state | meaning
// IDLE  | waiting for START; outputs hold last result
// CONV  | consuming one digit per edge, most significant first
// FIN   | DONE pulse; BIN/ERR/OVF valid
module bcd_to_bin_seq
   import bcd_pkg::*;
#(
   parameter int NUM_DIGITS = 3,
   parameter int OUT_W      = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    START,
   input  logic [4*NUM_DIGITS-1:0] BCD_IN,
   output logic [OUT_W-1:0]        BIN,
   output logic                    BUSY,
   output logic                    DONE,
   output logic                    ERR,
   output logic                    OVF
);

   localparam int CNT_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   bcd_state_e              state;
   logic [4*NUM_DIGITS-1:0] sreg;
   logic [OUT_W-1:0]        acc;
   logic [CNT_W-1:0]        cnt;
   logic                    ovf_f;
   logic                    bad_digit;
   logic [OUT_W-1:0]        mac_acc;
   logic                    mac_ovf;

   // Any nibble above 9 on the input bus marks the capture as invalid.
   always_comb begin
      bad_digit = 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (BCD_IN[4*i +: 4] > BCD_MAX) bad_digit = 1'b1;
      end
   end

   bcd_mac_step #(.OUT_W(OUT_W)) u_mac (
      .acc      (acc),
      .digit    (sreg[4*NUM_DIGITS-1 -: 4]),
      .acc_next (mac_acc),
      .ovf      (mac_ovf)
   );

   // Control FSM with registered handshake and result outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         sreg  <= '0;
         acc   <= '0;
         cnt   <= '0;
         ovf_f <= 1'b0;
         BIN   <= '0;
         BUSY  <= 1'b0;
         DONE  <= 1'b0;
         ERR   <= 1'b0;
         OVF   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               DONE <= 1'b0;
               if (START) begin
                  sreg  <= BCD_IN;
                  acc   <= '0;
                  cnt   <= CNT_W'(NUM_DIGITS - 1);
                  ovf_f <= 1'b0;
                  OVF   <= 1'b0;
                  BUSY  <= 1'b1;
                  if (bad_digit) begin
                     ERR   <= 1'b1;
                     BIN   <= '0;
                     DONE  <= 1'b1;
                     state <= FIN;
                  end else begin
                     ERR   <= 1'b0;
                     state <= CONV;
                  end
               end
            end
            CONV: begin
               acc   <= mac_acc;
               ovf_f <= ovf_f | mac_ovf;
               sreg  <= sreg << 4;
               cnt   <= cnt - CNT_W'(1);
               if (cnt == '0) begin
                  BIN   <= mac_acc;
                  OVF   <= ovf_f | mac_ovf;
                  DONE  <= 1'b1;
                  state <= FIN;
               end
            end
            FIN: begin
               DONE  <= 1'b0;
               BUSY  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               DONE  <= 1'b0;
               BUSY  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Self-checking bench: default 3-digit/8-bit instance plus a 4-digit/12-bit instance.
module tb_bcd_to_bin_seq;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start_a = 1'b0, start_b = 1'b0;
   logic [11:0] bcd_a = '0;
   logic [15:0] bcd_b = '0;
   logic [7:0]  bin_a;
   logic [11:0] bin_b;
   logic        busy_a, done_a, err_a, ovf_a;
   logic        busy_b, done_b, err_b, ovf_b;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   bcd_to_bin_seq #(.NUM_DIGITS(3), .OUT_W(8)) dut_a (
      .clk(clk), .rst_n(rst_n), .START(start_a), .BCD_IN(bcd_a),
      .BIN(bin_a), .BUSY(busy_a), .DONE(done_a), .ERR(err_a), .OVF(ovf_a)
   );

   bcd_to_bin_seq #(.NUM_DIGITS(4), .OUT_W(12)) dut_b (
      .clk(clk), .rst_n(rst_n), .START(start_b), .BCD_IN(bcd_b),
      .BIN(bin_b), .BUSY(busy_b), .DONE(done_b), .ERR(err_b), .OVF(ovf_b)
   );

   task automatic chk(input string tag, input int obs, input int exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", tag, obs, obs, exp, exp);
      end
   endtask

   // Reference: decimal value of the digits, then range/validity rules.
   function automatic void model(input logic [15:0] bcd, input int nd, input int w,
                                 output int bin, output bit err, output bit ovf);
      longint val = 0;
      longint maxv = (64'd1 << w) - 1;
      logic [15:0] b = bcd;
      err = 0;
      for (int k = nd - 1; k >= 0; k--) begin
         int d = int'((b >> (4*k)) & 16'hF);
         if (d > 9) err = 1;
         val = val * 10 + d;
      end
      if (err) begin
         bin = 0; ovf = 0;
      end else if (val > maxv) begin
         bin = int'(maxv); ovf = 1;
      end else begin
         bin = int'(val); ovf = 0;
      end
   endfunction

   function automatic int obs_bin(input int sel);
      return sel ? int'(bin_b) : int'(bin_a);
   endfunction

   task automatic run(input int sel, input logic [15:0] bcd);
      int nd, w, eb, edges;
      bit ee, eo, d;
      nd = sel ? 4 : 3;
      w  = sel ? 12 : 8;
      model(bcd, nd, w, eb, ee, eo);
      @(negedge clk);
      if (sel != 0) begin bcd_b = bcd; start_b = 1'b1; end
      else begin bcd_a = bcd[11:0]; start_a = 1'b1; end
      @(posedge clk); #1;
      chk("busy_after_accept", int'(sel ? busy_b : busy_a), 1);
      @(negedge clk);
      start_a = 1'b0; start_b = 1'b0;
      bcd_a = 12'($urandom); bcd_b = 16'($urandom);
      edges = 0;
      d = sel ? done_b : done_a;
      while (!d && edges < 20) begin
         @(posedge clk); edges++; @(negedge clk);
         d = sel ? done_b : done_a;
      end
      chk("done_seen", int'(d), 1);
      chk("latency", edges, ee ? 0 : nd);
      chk("bin", obs_bin(sel), eb);
      chk("err", int'(sel ? err_b : err_a), int'(ee));
      chk("ovf", int'(sel ? ovf_b : ovf_a), int'(eo));
      chk("busy_fin", int'(sel ? busy_b : busy_a), 1);
      @(negedge clk);
      chk("done_pulse_end", int'(sel ? done_b : done_a), 0);
      chk("busy_idle", int'(sel ? busy_b : busy_a), 0);
      chk("bin_hold", obs_bin(sel), eb);
      chk("err_hold", int'(sel ? err_b : err_a), int'(ee));
      chk("ovf_hold", int'(sel ? ovf_b : ovf_a), int'(eo));
   endtask

   function automatic logic [15:0] rand_bcd(input int nd);
      logic [15:0] v = '0;
      if ($urandom_range(0, 4) == 0) return 16'($urandom);
      for (int k = 0; k < nd; k++) v = v | (16'($urandom_range(0, 9)) << (4*k));
      return v;
   endfunction

   initial begin
      int edges;
      #12;
      chk("rst_bin", int'(bin_a), 0);
      chk("rst_busy", int'(busy_a), 0);
      chk("rst_done", int'(done_a), 0);
      chk("rst_err", int'(err_a), 0);
      chk("rst_ovf", int'(ovf_a), 0);
      chk("rst_bin_b", int'(bin_b), 0);
      @(negedge clk); rst_n = 1'b1;

      run(0, 16'h255);
      run(0, 16'h256);
      run(0, 16'h999);
      run(0, 16'h000);
      run(0, 16'h1A3);
      run(0, 16'h042);

      // START held high: second conversion only after returning to IDLE.
      @(negedge clk); bcd_a = 12'h128; start_a = 1'b1;
      @(posedge clk);
      @(negedge clk); bcd_a = 12'h007;
      edges = 0;
      while (!done_a && edges < 20) begin @(posedge clk); edges++; @(negedge clk); end
      chk("hold_first_lat", edges, 3);
      chk("hold_first_bin", int'(bin_a), 8'h80);
      @(negedge clk);
      chk("hold_idle_busy", int'(busy_a), 0);
      edges = 0;
      while (!done_a && edges < 20) begin @(posedge clk); edges++; @(negedge clk); end
      chk("hold_second_lat", edges, 4);
      chk("hold_second_bin", int'(bin_a), 8'h07);
      start_a = 1'b0;
      @(negedge clk); @(negedge clk);

      // Reset mid-conversion aborts without DONE.
      bcd_a = 12'h200; start_a = 1'b1;
      @(posedge clk);
      @(negedge clk); start_a = 1'b0;
      @(posedge clk); #2; rst_n = 1'b0; #1;
      chk("abort_bin", int'(bin_a), 0);
      chk("abort_busy", int'(busy_a), 0);
      chk("abort_done", int'(done_a), 0);
      chk("abort_err", int'(err_a), 0);
      chk("abort_ovf", int'(ovf_a), 0);
      @(negedge clk); rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("abort_no_done", int'(done_a), 0);
      end
      run(0, 16'h010);

      run(1, 16'h4095);
      run(1, 16'h4096);
      run(1, 16'h9999);

      for (int i = 0; i < 25; i++) run(0, rand_bcd(3));
      for (int i = 0; i < 10; i++) run(1, rand_bcd(4));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/bcd_to_bin_seq.md
Name: bcd_to_bin_seq

Overview:
Sequential decimal-to-binary converter: the inverse of the binary-to-BCD/7-segment display path.
- Accepts NUM_DIGITS packed BCD digits from switch/keypad entry and produces an OUT_W-bit unsigned binary value.
- Converts with one multiply-by-ten-and-add step per clock, using a start/busy/done handshake.
- Feeds operand registers of the ALU datapath; its results can be echoed back through the display decoder.

Parameters:
NUM_DIGITS, 3, number of BCD digits in BCD_IN (most significant nibble first)
OUT_W, 8, width of BIN; saturation limit is 2^OUT_W-1

Ports:
clk  in  1  single system clock, rising edge
rst_n  in  1  asynchronous, active-low reset
START  in  1  request conversion; sampled only in IDLE
BCD_IN  in  4*NUM_DIGITS  packed digits, [4*NUM_DIGITS-1 -: 4] = most significant
BIN  out  OUT_W  converted result, registered, held until next DONE
BUSY  out  1  high whenever FSM is not IDLE
DONE  out  1  single-cycle pulse; BIN/ERR/OVF valid in that cycle
ERR  out  1  a captured digit was >9
OVF  out  1  decimal value exceeded 2^OUT_W-1; BIN saturated

Behaviour:
- Reset (async, rst_n=0): state=IDLE; BIN=0, BUSY=0, DONE=0, ERR=0, OVF=0; internal shift register, accumulator and counter cleared.
- States: IDLE, CONV, FIN.
- IDLE with START=1 at an edge (accept edge):
  - Capture BCD_IN into the digit shift register; acc=0; cnt=NUM_DIGITS-1; clear ERR and OVF.
  - If any captured nibble >9: go to FIN with ERR=1, BIN=0, OVF=0. This is the error latency of 1 edge.
  - Otherwise: go to CONV.
- CONV, each edge:
  - acc_next = acc*10 + top nibble; shift the register left 4 bits; cnt decrements.
  - If acc_next > 2^OUT_W-1: clamp acc to 2^OUT_W-1 and set the internal ovf flag. The flag is sticky for this conversion.
  - The intermediate product uses OUT_W+4 bits, enough for (2^OUT_W-1)*10+9.
  - On the edge where cnt==0: load BIN=acc_next (clamped) and OVF=ovf flag, then go to FIN.
- FIN: DONE=1 for exactly this one cycle; the next edge returns to IDLE unconditionally.
- Latency: START accepted at edge E0 → digits processed at E1..E_NUM_DIGITS → DONE high in the cycle after E_NUM_DIGITS (3 edges for the default).
- BUSY=1 in CONV and FIN. START while BUSY=1 is ignored (not queued). Earliest next accept is the first edge in IDLE after FIN.
- BCD_IN changes after the accept edge have no effect on the current conversion.
- ERR and OVF hold their values after DONE until the next accept edge clears them. BIN holds its value until the next DONE.
- On an ERR conversion, BIN is forced to 0.
- rst_n asserted mid-conversion aborts immediately to reset values; no DONE is produced.
- All outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package (bcd_pkg):
  - FSM state typedef/encoding: IDLE=2'd0, CONV=2'd1, FIN=2'd2.
  - BCD_MAX=4'd9.
  - DEC_BASE=10.
  - Shared with the display decoder and the future bin_to_bcd block.
- One natural sub-module: bcd_mac_step.
  - Combinational: acc*10 + digit, with saturation to OUT_W and an ovf output.
  - Instantiated once in the CONV datapath.
- Digit validity check is inline in the parent (NUM_DIGITS nibble compares at capture).

Test Plan:
- Reset, then BCD_IN=12'h255, START pulse → BUSY high from E0; DONE pulse after E3; BIN=8'hFF, ERR=0, OVF=0.
- BCD_IN=12'h256 → BIN=8'hFF, OVF=1, ERR=0; then BCD_IN=12'h999 → BIN=8'hFF, OVF=1; then BCD_IN=12'h000 → BIN=0, OVF=0.
- BCD_IN=12'h1A3, START → DONE in the cycle after E0 (latency 1); ERR=1, BIN=0, OVF=0; next BCD_IN=12'h042 → ERR cleared at accept, BIN=8'h2A.
- BCD_IN=12'h128, START; hold START=1 and change BCD_IN to 12'h007 during CONV/FIN → first result BIN=8'h80. A second conversion starts only at the first IDLE edge and yields BIN=8'h07.
- Start 12'h200, drive rst_n=0 after E1 → all outputs 0 asynchronously, no DONE pulse; release reset, convert 12'h010 → BIN=8'h0A after 3 edges.
- Parameter sweep NUM_DIGITS=4, OUT_W=12: BCD_IN=16'h4095 → BIN=12'hFFF, OVF=0, DONE after E4; 16'h4096 → BIN=12'hFFF, OVF=1.
